reg_bank_write_64: RTL and testbench
====================================

# reg_bank_write_64

Write-side counterpart to the 64-way register read multiplexer: a 64-entry × 32-bit register bank that accepts write requests from the internal bus, decodes the 6-bit destination select into one-hot load enables, and commits the data one cycle later. All 64 registers are exposed as a flat vector for the read mux. A sequential bulk-clear engine zeros the bank over 64 cycles on request.

## Interface
Parameters:
- SEL_WIDTH, 6, destination select width (bank depth = 2^SEL_WIDTH = 64)
- DATA_WIDTH, 32, register width
- CNT_WIDTH, 16, committed-write counter width

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- wr_valid  input  1  write request valid
- wr_ready  output  1  bank can accept a request this cycle
- wr_sel  input  SEL_WIDTH  destination register index
- wr_data  input  DATA_WIDTH  write data
- clr_req  input  1  bulk-clear request, sampled only in IDLE
- busy  output  1  clear in progress
- ld_en  output  64  one-hot load enable of the write committing this cycle
- r_flat  output  64*DATA_WIDTH  register contents; register i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- wr_count  output  CNT_WIDTH  number of committed writes, modulo 2^CNT_WIDTH

## Operation
- FSM states: IDLE, CLEAR.
- IDLE: wr_ready=1, busy=0. Handshake fires when wr_valid && wr_ready at an edge; request captured into the pending stage (p_valid, p_sel, p_data).
- Commit stage: while p_valid=1, ld_en = onehot(p_sel), else ld_en=0. At the next edge register[p_sel] <= p_data, wr_count increments by 1 (wraps 0xFFFF→0x0000).
- Back-to-back requests accepted every cycle; writes commit in acceptance order; repeated index: last write wins.
- IDLE → CLEAR when clr_req=1 at an edge. A write handshaking on that same edge is still captured and commits during the first CLEAR cycle.
- CLEAR: wr_ready=0, busy=1; 6-bit clear index cl_idx starts at 0, zeros register[cl_idx] each cycle, increments; after index 63 is zeroed, return to IDLE. Duration exactly 64 cycles. clr_req ignored in CLEAR.
- Same-edge conflict (pending commit and clear of the same index): clear wins; wr_count still increments. ld_en still reflects the pending write.
- wr_valid while wr_ready=0: not captured; requester holds.
- rst (any state, including mid-CLEAR or with p_valid set): state=IDLE, all 64 registers=0, p_valid=0, cl_idx=0, wr_count=0, ld_en=0, busy=0, wr_ready=1 after the reset edge. Pending write discarded, not counted.

## Timing
- Accept at edge N → ld_en valid during cycle N..N+1 window (after edge N) → register and wr_count updated at edge N+1, visible on r_flat immediately after edge N+1. Write latency: 1 cycle from handshake edge to committed.
- clr_req sampled at edge C → busy=1, wr_ready=0 from C to C+64; register i zeroed at edge C+1+i; IDLE, wr_ready=1 after edge C+64.
- Throughput: 1 write/cycle in IDLE.
- All outputs registered except ld_en (decoded from registered p_sel/p_valid) and wr_ready/busy (decoded from registered state).

## Configuration
- RISCV_ZERO_REG_EN defined: register 0 hard-wired to zero; a write with p_sel=0 commits nothing, ld_en[0] never asserts, wr_count does not increment. r_flat bits [DATA_WIDTH-1:0] are constant 0.
- Undefined: register 0 is an ordinary register, writable and counted like all others.

## Test plan
- Reset then write sel=5, data=0xDEADBEEF → ld_en=64'h20 one cycle after handshake; r_flat reg5=0xDEADBEEF next edge; wr_count=1.
- Back-to-back writes sel=10 data=0x1, 0x2, 0x3 on consecutive cycles → reg10=0x3, wr_count=3, wr_ready held 1 throughout.
- Write sel=7 data=0xAA together with clr_req → busy=1 next cycle for 64 cycles, wr_ready=0; reg7 finally 0; wr_count=1; wr_ready=1 after 64 cycles.
- Assert rst at cycle 20 of CLEAR with a pending write → all registers 0, wr_count=0, state IDLE, wr_ready=1 after reset edge.
- Write sel=0 data=0x55: with RISCV_ZERO_REG_EN → reg0=0, ld_en=0, wr_count unchanged; without → reg0=0x55, wr_count+1.
- 65536 committed writes → wr_count wraps to 0x0000.

Source files
------------

// File: rtl/reg_bank_write_64.sv
// 64-entry register bank with a one-cycle write commit stage and a 64-cycle bulk-clear engine.
// Optional build macro RISCV_ZERO_REG_EN hard-wires register 0 to zero.
module reg_bank_write_64 #(
  parameter int unsigned SEL_WIDTH  = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  wr_valid,
  output logic                                  wr_ready,
  input  logic [SEL_WIDTH-1:0]                  wr_sel,
  input  logic [DATA_WIDTH-1:0]                 wr_data,
  input  logic                                  clr_req,
  output logic                                  busy,
  output logic [(2**SEL_WIDTH)-1:0]             ld_en,
  output logic [(2**SEL_WIDTH)*DATA_WIDTH-1:0]  r_flat,
  output logic [CNT_WIDTH-1:0]                  wr_count
);

  localparam int unsigned Depth = 2 ** SEL_WIDTH;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                state_q, state_d;
  logic [SEL_WIDTH-1:0]  cl_idx_q, cl_idx_d;
  logic                  p_valid_q;
  logic [SEL_WIDTH-1:0]  p_sel_q;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic [DATA_WIDTH-1:0] regs_q [Depth];
  logic [CNT_WIDTH-1:0]  wr_count_q;
  logic                  accept;
  logic                  commit;

  assign accept = wr_valid && wr_ready;

  always_comb begin
    state_d  = state_q;
    cl_idx_d = cl_idx_q;
    wr_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      StIdle: begin
        wr_ready = 1'b1;
        if (clr_req) begin
          state_d  = StClear;
          cl_idx_d = '0;
        end
      end
      StClear: begin
        busy     = 1'b1;
        cl_idx_d = cl_idx_q + 1'b1;
        if (cl_idx_q == '1) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cl_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      cl_idx_q <= cl_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid_q <= 1'b0;
      p_sel_q   <= '0;
      p_data_q  <= '0;
    end else begin
      p_valid_q <= accept;
      if (accept) begin
        p_sel_q  <= wr_sel;
        p_data_q <= wr_data;
      end
    end
  end

  always_comb begin
    ld_en = '0;
    if (p_valid_q) begin
      ld_en[p_sel_q] = 1'b1;
    end
`ifdef RISCV_ZERO_REG_EN
    ld_en[0] = 1'b0;
`endif
  end

  // A suppressed register-0 write leaves ld_en all zero, so it is not counted either.
  assign commit = |ld_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_q <= '0;
    end else if (commit) begin
      wr_count_q <= wr_count_q + 1'b1;
    end
  end

  assign wr_count = wr_count_q;

  // Clear takes priority over a commit landing on the same index in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (busy && (cl_idx_q == SEL_WIDTH'(i))) begin
          regs_q[i] <= '0;
        end else if (ld_en[i]) begin
          regs_q[i] <= p_data_q;
        end
      end
    end
  end

  always_comb begin
    r_flat = '0;
    for (int i = 0; i < Depth; i++) begin
      r_flat[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
`ifdef RISCV_ZERO_REG_EN
    r_flat[DATA_WIDTH-1:0] = '0;
`endif
  end

endmodule

// File: tb/tb_reg_bank_write_64.sv
// Directed self-checking bench for reg_bank_write_64: commit latency, back-to-back writes,
// bulk clear, mid-clear reset, register-0 behaviour and write-counter wrap.
module tb_reg_bank_write_64;

  logic          clk;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [5:0]    wr_sel;
  logic [31:0]   wr_data;
  logic          clr_req;
  logic          busy;
  logic [63:0]   ld_en;
  logic [2047:0] r_flat;
  logic [15:0]   wr_count;

  int checks = 0;
  int errors = 0;

  reg_bank_write_64 dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .clr_req  (clr_req),
    .busy     (busy),
    .ld_en    (ld_en),
    .r_flat   (r_flat),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] reg_at(input int i);
    return r_flat[i*32 +: 32];
  endfunction

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_sel   = '0;
    wr_data  = '0;
    clr_req  = 1'b0;
    step();
    step();
    check_eq("rst_ready", 64'(wr_ready), 64'd1);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_ld_en", ld_en, 64'd0);
    check_eq("rst_count", 64'(wr_count), 64'd0);
    check_eq("rst_reg5", 64'(reg_at(5)), 64'd0);
    rst = 1'b0;

    // Single write, one-cycle commit latency.
    wr_valid = 1'b1; wr_sel = 6'd5; wr_data = 32'hDEADBEEF;
    step();
    wr_valid = 1'b0;
    check_eq("w5_ld_en", ld_en, 64'h20);
    check_eq("w5_pre_reg", 64'(reg_at(5)), 64'd0);
    check_eq("w5_pre_count", 64'(wr_count), 64'd0);
    step();
    check_eq("w5_reg", 64'(reg_at(5)), 64'hDEADBEEF);
    check_eq("w5_count", 64'(wr_count), 64'd1);
    check_eq("w5_ld_idle", ld_en, 64'd0);

    // Back-to-back writes to one index; last one wins.
    wr_valid = 1'b1; wr_sel = 6'd10; wr_data = 32'h1;
    step();
    check_eq("b2b_ready1", 64'(wr_ready), 64'd1);
    wr_data = 32'h2;
    step();
    check_eq("b2b_ready2", 64'(wr_ready), 64'd1);
    check_eq("b2b_first", 64'(reg_at(10)), 64'h1);
    wr_data = 32'h3;
    step();
    check_eq("b2b_ready3", 64'(wr_ready), 64'd1);
    check_eq("b2b_ld_en", ld_en, 64'h400);
    wr_valid = 1'b0;
    step();
    check_eq("b2b_reg10", 64'(reg_at(10)), 64'h3);
    check_eq("b2b_count", 64'(wr_count), 64'd4);

    // Preload reg63 so the end of the clear sweep is observable.
    wr_valid = 1'b1; wr_sel = 6'd63; wr_data = 32'h63;
    step();
    wr_valid = 1'b0;
    step();
    check_eq("pre63", 64'(reg_at(63)), 64'h63);

    // Write together with clr_req; a held request during CLEAR must not be taken.
    wr_valid = 1'b1; wr_sel = 6'd7; wr_data = 32'hAA; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    wr_sel  = 6'd9; wr_data = 32'h99;
    check_eq("clr_busy0", 64'(busy), 64'd1);
    check_eq("clr_ready0", 64'(wr_ready), 64'd0);
    check_eq("clr_ld7", ld_en, 64'h80);
    step();
    check_eq("clr_reg7_set", 64'(reg_at(7)), 64'hAA);
    check_eq("clr_count", 64'(wr_count), 64'd6);
    check_eq("clr_no_capture", ld_en, 64'd0);
    for (int k = 2; k <= 64; k++) begin
      step();
      if (k < 64) check_eq("clr_busy", 64'(busy), 64'd1);
      if (k == 8) check_eq("clr_reg7_zero", 64'(reg_at(7)), 64'd0);
      if (k == 63) check_eq("clr_reg63_kept", 64'(reg_at(63)), 64'h63);
    end
    check_eq("clr_done_busy", 64'(busy), 64'd0);
    check_eq("clr_done_ready", 64'(wr_ready), 64'd1);
    check_eq("clr_reg63_zero", 64'(reg_at(63)), 64'd0);
    check_eq("clr_reg5_zero", 64'(reg_at(5)), 64'd0);
    check_eq("clr_held_ld", ld_en, 64'd0);
    step();
    wr_valid = 1'b0;
    check_eq("held_ld9", ld_en, 64'h200);
    step();
    check_eq("held_reg9", 64'(reg_at(9)), 64'h99);
    check_eq("held_count", 64'(wr_count), 64'd7);

    // Reset in the middle of CLEAR.
    wr_valid = 1'b1; wr_sel = 6'd40; wr_data = 32'h40;
    step();
    wr_valid = 1'b0;
    step();
    check_eq("pre40", 64'(reg_at(40)), 64'h40);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int k = 1; k < 20; k++) step();
    check_eq("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1; wr_valid = 1'b1; wr_sel = 6'd12; wr_data = 32'h12;
    step();
    check_eq("midrst_reg40", 64'(reg_at(40)), 64'd0);
    check_eq("midrst_count", 64'(wr_count), 64'd0);
    check_eq("midrst_ready", 64'(wr_ready), 64'd1);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_ld", ld_en, 64'd0);

    // Reset while a write is pending: it must be dropped and not counted.
    rst = 1'b0;
    step();
    rst = 1'b1; wr_valid = 1'b0;
    step();
    rst = 1'b0;
    check_eq("prst_ld", ld_en, 64'd0);
    step();
    check_eq("prst_reg12", 64'(reg_at(12)), 64'd0);
    check_eq("prst_count", 64'(wr_count), 64'd0);

    // Register 0 write.
    wr_valid = 1'b1; wr_sel = 6'd0; wr_data = 32'h55;
    step();
    wr_valid = 1'b0;
`ifdef RISCV_ZERO_REG_EN
    check_eq("r0_ld", ld_en, 64'd0);
    step();
    check_eq("r0_reg", 64'(reg_at(0)), 64'd0);
    check_eq("r0_count", 64'(wr_count), 64'd0);
`else
    check_eq("r0_ld", ld_en, 64'd1);
    step();
    check_eq("r0_reg", 64'(reg_at(0)), 64'h55);
    check_eq("r0_count", 64'(wr_count), 64'd1);
`endif

    // Counter wrap: burst up to 0xFFFF, then one more write.
    begin
      int n;
      n = 65535 - int'(wr_count);
      wr_valid = 1'b1; wr_sel = 6'd1; wr_data = 32'h1;
      for (int k = 0; k < n; k++) step();
      wr_valid = 1'b0;
      step();
      check_eq("wrap_ffff", 64'(wr_count), 64'hFFFF);
      wr_valid = 1'b1; wr_data = 32'hCAFEF00D;
      step();
      wr_valid = 1'b0;
      step();
      check_eq("wrap_zero", 64'(wr_count), 64'd0);
      check_eq("wrap_reg1", 64'(reg_at(1)), 64'hCAFEF00D);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
